// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_stage_pkg;

    // Default first fetch address after reset.
    localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

    // Canonical NOP (addi x0, x0, 0). Shown on id_inst whenever id_valid is low.
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    // Front-end sequencing states.
    typedef enum logic [1:0] {
        IF_BOOT  = 2'd0,
        IF_RUN   = 2'd1,
        IF_DRAIN = 2'd2
    } if_state_e;

    // One instruction-buffer / pending-queue entry.
    typedef struct packed {
        logic [63:0] addr;
        logic [31:0] inst;
    } fetch_entry_t;

    // Fetch addresses are always word aligned; the low two bits are dropped.
    function automatic logic [63:0] align_pc(input logic [63:0] pc);
        return {pc[63:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Bus bundle between the fetch stage, instruction memory, decode and the
// branch-resolution logic.
//
// Handshake rules: a request or instruction moves on a rising clk edge where
// its valid and ready are both high. A producer's valid never depends on the
// consumer's ready in the same cycle. A redirect may withdraw a valid that has
// not yet been accepted (that request or instruction is flushed). The memory
// response channel has no ready: the fetch stage always takes a response.
interface if_stage_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;

    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [63:0] id_inst_addr;

    logic        redirect_valid;
    logic [63:0] redirect_pc;

    // Fetch-stage side.
    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data,
        output id_valid,
        output id_inst,
        output id_inst_addr,
        input  id_ready,
        input  redirect_valid,
        input  redirect_pc
    );

    // Environment side: memory, decode and branch resolution.
    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data,
        input  id_valid,
        input  id_inst,
        input  id_inst_addr,
        output id_ready,
        output redirect_valid,
        output redirect_pc
    );

endinterface

// File: rtl/if_stage_inst_fifo.sv
// Small circular FIFO of {addr, inst} entries with synchronous flush and an
// occupancy count. Used both as the instruction buffer and as the queue of
// addresses whose memory responses are still due.
module if_stage_inst_fifo
    import if_stage_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               push,
    input  fetch_entry_t       push_entry,
    input  logic               pop,
    output fetch_entry_t       head,
    output logic [CNT_W-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_ok;

    // Pointer advance with wrap at DEPTH (works for non power-of-two depths).
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Popping an empty FIFO is ignored. Pushes are not checked against full:
    // the owner's credit scheme guarantees there is always room.
    assign pop_ok = pop & (count_q != '0);

    // Next-state for storage, pointers and count; flush wins over push/pop.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = ptr_next(wr_ptr_q);
            end
            if (pop_ok) begin
                rd_ptr_d = ptr_next(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop_ok);
        end
    end

    // Register all FIFO state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch front end: owns the PC, issues instruction-memory
// requests under a credit limit, pairs in-order responses with their
// addresses, buffers them for decode and discards responses made stale by a
// redirect.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [63:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          BUF_DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    if_stage_if.master bus,
    output if_state_e  dbg_state
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    if_state_e        state_q, state_d;
    logic [63:0]      fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic [CNT_W-1:0] buf_count;
    logic [CNT_W-1:0] pend_count;
    fetch_entry_t     buf_head;
    fetch_entry_t     pend_head;
    fetch_entry_t     resp_entry;
    fetch_entry_t     pend_entry;

    logic [CNT_W-1:0] in_flight;
    logic [CNT_W-1:0] stale_total;
    logic             req_valid;
    logic             req_fire;
    logic             resp_drop;
    logic             resp_take;
    logic             id_valid;
    logic             id_pop;
    logic             unused_pend_bits;

    // Requests in flight plus buffered instructions never exceed BUF_DEPTH,
    // so these sums fit in CNT_W bits. outstanding and drop_cnt are never both
    // non-zero (requests only issue once draining has finished), so their sum
    // also fits.
    assign in_flight   = outstanding_q + buf_count;
    assign stale_total = outstanding_q + drop_cnt_q;

    // Request issue: running, not being redirected, and a buffer slot is
    // reserved for every request that could come back.
    assign req_valid = (state_q == IF_RUN) & ~bus.redirect_valid
                     & (in_flight < CNT_W'(BUF_DEPTH));
    assign req_fire  = req_valid & bus.imem_req_ready;

    // Response classification. A response with nothing outstanding and
    // nothing to drop is a protocol violation and falls through both terms.
    assign resp_drop = bus.imem_resp_valid & (drop_cnt_q != '0);
    assign resp_take = bus.imem_resp_valid & (drop_cnt_q == '0)
                     & (outstanding_q != '0) & ~bus.redirect_valid;

    // Decode side: a redirect hides the head entry in the cycle it flushes it.
    assign id_valid = (buf_count != '0) & ~bus.redirect_valid;
    assign id_pop   = id_valid & bus.id_ready;

    assign pend_entry = '{addr: fetch_pc_q, inst: 32'h0};
    assign resp_entry = '{addr: pend_head.addr, inst: bus.imem_resp_data};

    // Addresses of accepted requests, popped as their responses return.
    if_stage_inst_fifo #(.DEPTH(BUF_DEPTH)) u_pend_q (
        .clk        (clk),
        .rst        (rst),
        .flush      (bus.redirect_valid),
        .push       (req_fire),
        .push_entry (pend_entry),
        .pop        (resp_take),
        .head       (pend_head),
        .count      (pend_count)
    );

    // Returned instructions waiting for decode.
    if_stage_inst_fifo #(.DEPTH(BUF_DEPTH)) u_inst_buf (
        .clk        (clk),
        .rst        (rst),
        .flush      (bus.redirect_valid),
        .push       (resp_take),
        .push_entry (resp_entry),
        .pop        (id_pop),
        .head       (buf_head),
        .count      (buf_count)
    );

    // The pending queue carries addresses only, and its count mirrors
    // outstanding_q; those bits are deliberately left unused.
    assign unused_pend_bits = ^{pend_head.inst, pend_count};

    // Next-state for PC, request/drop bookkeeping and sequencing.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        if (bus.redirect_valid) begin
            // Everything still due from memory becomes stale; a response in
            // this very cycle is one of them and is discarded now.
            fetch_pc_d    = align_pc(bus.redirect_pc);
            outstanding_d = '0;
            drop_cnt_d    = stale_total
                          - ((bus.imem_resp_valid && (stale_total != '0)) ? CNT_W'(1) : '0);
            state_d       = (drop_cnt_d != '0) ? IF_DRAIN : IF_RUN;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 64'd4;
            end
            outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(resp_take);
            if (resp_drop) begin
                drop_cnt_d = drop_cnt_q - CNT_W'(1);
            end
            case (state_q)
                IF_BOOT:  state_d = IF_RUN;
                IF_RUN:   state_d = IF_RUN;
                IF_DRAIN: if (drop_cnt_d == '0) state_d = IF_RUN;
                default:  state_d = IF_BOOT;
            endcase
        end
    end

    // State register for the whole fetch controller.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IF_BOOT;
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.id_valid       = id_valid;
    assign bus.id_inst        = id_valid ? buf_head.inst : INST_NOP;
    assign bus.id_inst_addr   = id_valid ? buf_head.addr : 64'h0;
    assign dbg_state          = state_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: in-order memory model with per-request latency, decode
// sink and an expected-instruction queue, plus directed redirect/reset cases.
module tb_if_stage;
    import if_stage_pkg::*;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] exp_addr;
    } redir_vec_t;

    logic      clk;
    logic      rst;
    if_state_e dbg_state;

    if_stage_if bus ();

    if_stage #(.RESET_PC(RST_PC), .BUF_DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec;
    int          n_err;
    int          cyc;
    int          lat_lo, lat_hi;
    bit          rand_ready, rand_id;
    int          n_req, n_deliv;
    int          first_req_cyc, first_id_cyc;
    logic [63:0] exp_next_pc;
    logic [95:0] exp_q[$];
    logic [63:0] mq_addr[$];
    int          mq_due[$];
    redir_vec_t  vt[5];

    // Instruction word the memory model stores at an address.
    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'hC0DE_0003;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Observe one cycle's handshakes, away from the clock edge.
    task automatic sample();
        logic [95:0] e;
        if (bus.redirect_valid) begin
            check("redir_id_valid", 64'(bus.id_valid), 64'd0);
            check("redir_req_valid", 64'(bus.imem_req_valid), 64'd0);
        end
        if (!bus.id_valid) begin
            check("idle_inst", 64'(bus.id_inst), 64'(INST_NOP));
            check("idle_addr", bus.id_inst_addr, 64'd0);
        end
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            check("req_addr", bus.imem_req_addr, exp_next_pc);
            exp_q.push_back({exp_next_pc, inst_of(exp_next_pc)});
            mq_addr.push_back(bus.imem_req_addr);
            mq_due.push_back(cyc + int'($urandom_range(lat_hi, lat_lo)));
            exp_next_pc = exp_next_pc + 64'd4;
            n_req++;
            if (first_req_cyc < 0) first_req_cyc = cyc;
        end
        if (bus.id_valid && bus.id_ready) begin
            n_deliv++;
            if (first_id_cyc < 0) first_id_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL id_unexpected: got addr %h inst %h, required no delivery",
                         bus.id_inst_addr, bus.id_inst);
            end else begin
                e = exp_q.pop_front();
                check("id_addr", bus.id_inst_addr, e[95:32]);
                check("id_inst", 64'(bus.id_inst), 64'(e[31:0]));
            end
        end
        if (bus.redirect_valid) begin
            exp_q.delete();
            exp_next_pc = {bus.redirect_pc[63:2], 2'b00};
        end
    endtask

    // One clock: sample at negedge, then drive next-cycle inputs #1 after posedge.
    task automatic cycle();
        @(negedge clk);
        sample();
        @(posedge clk);
        cyc++;
        #1;
        bus.redirect_valid = 1'b0;
        if (rand_ready) bus.imem_req_ready = ($urandom_range(3, 0) != 0);
        if (rand_id)    bus.id_ready       = ($urandom_range(2, 0) != 0);
        if (!rst && mq_due.size() != 0 && mq_due[0] <= cyc) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = inst_of(mq_addr[0]);
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end else begin
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_data  = $urandom;
        end
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_redirect(input logic [63:0] pc);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        cycle();
    endtask

    // Count stale responses while draining; ends once RUN is observed.
    task automatic count_drain(output int drops);
        drops = 0;
        for (int i = 0; i < 20 && dbg_state == IF_DRAIN; i++) begin
            if (bus.imem_resp_valid) drops++;
            cycle();
        end
    endtask

    // Time limit.
    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  drops;
        bit  found;

        vt[0] = '{pc: 64'h0000_0000_8000_0206, exp_addr: 64'h0000_0000_8000_0204};
        vt[1] = '{pc: 64'h0000_0000_8000_0103, exp_addr: 64'h0000_0000_8000_0100};
        vt[2] = '{pc: 64'h0000_0000_0000_0001, exp_addr: 64'h0000_0000_0000_0000};
        vt[3] = '{pc: 64'hFFFF_FFFF_FFFF_FFFE, exp_addr: 64'hFFFF_FFFF_FFFF_FFFC};
        vt[4] = '{pc: 64'h1234_5678_9ABC_DEF5, exp_addr: 64'h1234_5678_9ABC_DEF4};

        n_vec = 0; n_err = 0; cyc = 0; n_req = 0; n_deliv = 0;
        first_req_cyc = -1; first_id_cyc = -1;
        lat_lo = 1; lat_hi = 1; rand_ready = 0; rand_id = 0;
        exp_next_pc = RST_PC;
        rst = 1'b0;
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        bus.id_ready        = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = 64'h0;

        // Reset values, visible before any clock edge.
        #1 rst = 1'b1;
        #2;
        check("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
        check("rst_req_addr", bus.imem_req_addr, RST_PC);
        check("rst_id_valid", 64'(bus.id_valid), 64'd0);
        check("rst_id_inst", 64'(bus.id_inst), 64'(INST_NOP));
        check("rst_id_addr", bus.id_inst_addr, 64'd0);
        check("rst_state", 64'(dbg_state), 64'(IF_BOOT));

        // Boot: one idle cycle, then fetch from the reset PC with 1-cycle memory.
        bus.imem_req_ready = 1'b1;
        bus.id_ready       = 1'b1;
        run(2);
        rst = 1'b0;
        check("boot_no_req", 64'(bus.imem_req_valid), 64'd0);
        cycle();
        check("run_state", 64'(dbg_state), 64'(IF_RUN));
        check("run_req_valid", 64'(bus.imem_req_valid), 64'd1);
        check("first_req_addr", bus.imem_req_addr, RST_PC);
        run(20);
        check("first_latency", 64'(first_id_cyc - first_req_cyc), 64'd2);
        check("boot_deliveries", 64'(n_deliv >= 8), 64'd1);

        // Decode stall: credit cap holds requests back, nothing lost afterwards.
        bus.id_ready = 1'b0;
        n_req = 0;
        run(6);
        check("stall_req_count", 64'(n_req <= 2), 64'd1);
        check("stall_req_valid", 64'(bus.imem_req_valid), 64'd0);
        check("stall_id_valid", 64'(bus.id_valid), 64'd1);
        bus.id_ready = 1'b1;
        n_deliv = 0;
        run(12);
        check("stall_recover", 64'(n_deliv >= 4), 64'd1);

        // Redirect with two requests outstanding and no response this cycle.
        lat_lo = 3; lat_hi = 3;
        run(8);
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (mq_addr.size() == 2 && !bus.imem_resp_valid && dbg_state == IF_RUN) found = 1;
            else cycle();
        end
        check("wait_two_out", 64'(found), 64'd1);
        do_redirect(64'h0000_0000_8000_0100);
        check("drain2_state", 64'(dbg_state), 64'(IF_DRAIN));
        check("drain2_no_req", 64'(bus.imem_req_valid), 64'd0);
        check("drain2_addr", bus.imem_req_addr, 64'h0000_0000_8000_0100);
        count_drain(drops);
        check("drain2_exit", 64'(dbg_state), 64'(IF_RUN));
        check("drain2_drops", 64'(drops), 64'd2);
        n_deliv = 0;
        run(12);
        check("drain2_deliv", 64'(n_deliv >= 2), 64'd1);

        // Redirect coinciding with a response while one more is outstanding.
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (mq_addr.size() == 1 && bus.imem_resp_valid && dbg_state == IF_RUN) found = 1;
            else cycle();
        end
        check("wait_resp_plus_one", 64'(found), 64'd1);
        do_redirect(64'h0000_0000_8000_0200);
        check("drain1_state", 64'(dbg_state), 64'(IF_DRAIN));
        count_drain(drops);
        check("drain1_exit", 64'(dbg_state), 64'(IF_RUN));
        check("drain1_drops", 64'(drops), 64'd1);
        n_deliv = 0;
        run(12);
        check("drain1_deliv", 64'(n_deliv >= 2), 64'd1);

        // Redirect target table: alignment and 64-bit wrap of the next fetch.
        lat_lo = 1; lat_hi = 3;
        for (int i = 0; i < 5; i++) begin
            run(int'($urandom_range(6, 1)));
            do_redirect(vt[i].pc);
            check("redir_addr", bus.imem_req_addr, vt[i].exp_addr);
            n_deliv = 0;
            run(15);
            check("redir_deliv", 64'(n_deliv >= 2), 64'd1);
        end

        // Random back-pressure and redirects.
        rand_ready = 1; rand_id = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(24, 0) == 0) begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = {$urandom, $urandom};
            end
            cycle();
        end
        rand_ready = 0; rand_id = 0;
        bus.imem_req_ready = 1'b1;
        bus.id_ready       = 1'b1;
        n_deliv = 0;
        run(15);
        check("random_settle_deliv", 64'(n_deliv >= 2), 64'd1);

        // Asynchronous reset with a full buffer, then restart from the reset PC.
        lat_lo = 1; lat_hi = 1;
        bus.id_ready = 1'b0;
        run(8);
        check("pre_rst_id_valid", 64'(bus.id_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_id_valid", 64'(bus.id_valid), 64'd0);
        check("arst_req_valid", 64'(bus.imem_req_valid), 64'd0);
        check("arst_req_addr", bus.imem_req_addr, RST_PC);
        check("arst_id_inst", 64'(bus.id_inst), 64'(INST_NOP));
        check("arst_state", 64'(dbg_state), 64'(IF_BOOT));
        mq_addr.delete();
        mq_due.delete();
        exp_q.delete();
        exp_next_pc = RST_PC;
        bus.imem_resp_valid = 1'b0;
        run(2);
        rst = 1'b0;
        bus.id_ready = 1'b1;
        n_deliv = 0;
        run(20);
        check("restart_deliv", 64'(n_deliv >= 6), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
